// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg: shared FSM encoding and default scan parameters
package truth_table_scanner_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;
  localparam int N_IN_DEF = 4;
  localparam int SETTLE_DEF = 2;
endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// truth_table_scanner_settle_timer: loadable 4-bit down-counter with zero flag
//   clk, rst_n    : clock, async active-low reset
//   load_i        : load load_value_i this edge (wins over decrement)
//   load_value_i  : value to load
//   zero_o        : count is zero; counter rests at zero
module truth_table_scanner_settle_timer
  import truth_table_scanner_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_value_i,
  output logic       zero_o
);
  logic [3:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == 4'd0;
  always_comb cnt_d = load_i ? load_value_i : zero_o ? cnt_q : cnt_q - 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks all input vectors of an external circuit and records its truth table
//   clk, rst_n : clock, async active-low reset
//   start_i    : request a scan (accepted only in IDLE)
//   abcd_o     : vector driven to the circuit, MSB = A
//   f_i        : circuit output for abcd_o
//   busy_o     : scan in progress
//   done_o     : one-cycle pulse, table_o/ones_o valid
//   table_o    : bit i = F(i)
//   ones_o     : number of set bits in table_o
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  output logic [N_IN-1:0]        abcd_o,
  input  logic                   f_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [(1<<N_IN)-1:0]   table_o,
  output logic [N_IN:0]          ones_o
);
  state_e state_q, state_d;
  logic [N_IN-1:0] abcd_q, abcd_d;
  logic [(1<<N_IN)-1:0] table_q, table_d;
  logic [N_IN:0] ones_q, ones_d;
  logic busy_q, busy_d, done_q, done_d;
  logic load, zero;
  truth_table_scanner_settle_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .load_value_i (4'(SETTLE)),
    .zero_o       (zero)
  );
  always_comb begin
    state_d = state_q;
    abcd_d  = abcd_q;
    table_d = table_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = WAIT;
        abcd_d  = '0;
        table_d = '0;
        ones_d  = '0;
        busy_d  = 1'b1;
        load    = 1'b1;
      end
      WAIT: if (zero) begin
        table_d[abcd_q] = f_i;
        ones_d = ones_q + (N_IN+1)'(f_i);
        if (abcd_q == {N_IN{1'b1}}) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          abcd_d = abcd_q + N_IN'(1);
          load   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        abcd_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      abcd_q  <= '0;
      table_q <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abcd_q  <= abcd_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign abcd_o  = abcd_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign table_o = table_q;
  assign ones_o  = ones_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: randomized scans of two scanners (SETTLE=2 and SETTLE=0) against a truth-table model
module tb_truth_table_scanner;
  localparam int SA = 2;
  localparam int SB = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [2];
  logic f [2];
  logic [3:0] abcd [2];
  logic busy [2];
  logic done [2];
  logic [15:0] tbl [2];
  logic [4:0] ones [2];
  int mode [2];
  logic [15:0] pat [2];
  bit glitch [2];
  int age [2];
  logic [3:0] last [2];
  logic [15:0] prev [2];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  truth_table_scanner #(.N_IN(4), .SETTLE(SA)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .abcd_o(abcd[0]), .f_i(f[0]),
    .busy_o(busy[0]), .done_o(done[0]), .table_o(tbl[0]), .ones_o(ones[0])
  );
  truth_table_scanner #(.N_IN(4), .SETTLE(SB)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .abcd_o(abcd[1]), .f_i(f[1]),
    .busy_o(busy[1]), .done_o(done[1]), .table_o(tbl[1]), .ones_o(ones[1])
  );
  function automatic logic ref_f(int m, logic [3:0] v, logic [15:0] p);
    return m == 0 ? ((v[3] ^ v[2]) & (v[1] | ~v[0])) : m == 1 ? 1'b1 : m == 2 ? 1'b0 :
           m == 3 ? v[0] : m == 4 ? ^v : p[v];
  endfunction
  function automatic logic [15:0] ref_table(int m, logic [15:0] p);
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = ref_f(m, 4'(v), p);
    return t;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // f follows the model, except in glitch mode where it is random until the sampling cycle of each vector
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      age[i] = !busy[i] ? -1 : (abcd[i] != last[i]) ? 0 : age[i] + 1;
      last[i] = abcd[i];
      f[i] = (glitch[i] && age[i] != (i == 0 ? SA : SB)) ? 1'($urandom_range(1)) : ref_f(mode[i], abcd[i], pat[i]);
    end
  task automatic scan(input int i, input int m, input logic [15:0] p, input bit g, input bit poke);
    int s, cyc, bcnt;
    bit got_done, seq_bad;
    logic [15:0] exp_t;
    s = i == 0 ? SA : SB;
    mode[i] = m;
    pat[i] = p;
    glitch[i] = g;
    exp_t = ref_table(m, p);
    check("hold_table", tbl[i], prev[i]);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    check("clear_table", tbl[i], 0);
    check("clear_ones", ones[i], 0);
    bcnt = busy[i] ? 1 : 0;
    cyc = 1;
    got_done = 0;
    seq_bad = 0;
    while (cyc < 2000 && !got_done) begin
      if (busy[i] && abcd[i] != 4'((cyc - 1) / (s + 1))) seq_bad = 1;
      if (poke && cyc == 5) start[i] = 1'b1;
      if (poke && cyc == 6) start[i] = 1'b0;
      @(negedge clk);
      cyc++;
      if (done[i]) got_done = 1;
      else if (busy[i]) bcnt++;
    end
    check("done_seen", 32'(got_done), 1);
    check("done_latency", cyc, 1 + 16 * (s + 1));
    check("busy_cycles", bcnt, 16 * (s + 1));
    check("abcd_seq", 32'(seq_bad), 0);
    check("busy_at_done", busy[i], 0);
    check("table", tbl[i], exp_t);
    check("ones", ones[i], $countones(exp_t));
    if (poke) start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    check("done_pulse", done[i], 0);
    check("idle_busy", busy[i], 0);
    check("idle_abcd", abcd[i], 0);
    check("table_kept", tbl[i], exp_t);
    prev[i] = exp_t;
  endtask
  initial begin
    int cyc;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mode[i] = 2; pat[i] = 16'h0; glitch[i] = 0; prev[i] = 16'h0;
      age[i] = -1; last[i] = 4'h0; f[i] = 1'b0;
    end
    #12;
    check("rst_abcd", abcd[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_table", tbl[0], 0);
    check("rst_ones", ones[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    scan(0, 0, 16'h0, 0, 0);
    check("xor_const", tbl[0], 16'h0DD0);
    scan(0, 1, 16'h0, 0, 0);
    check("ones_max", ones[0], 16);
    scan(0, 2, 16'h0, 0, 0);
    scan(1, 3, 16'h0, 0, 0);
    check("abcd0_const", tbl[1], 16'hAAAA);
    scan(0, 4, 16'h0, 1, 0);
    check("parity_const", tbl[0], 16'h6996);
    scan(0, 5, 16'($urandom), 0, 1);
    scan(0, 5, 16'($urandom), 1, 0);
    scan(1, 5, 16'($urandom), 0, 1);
    mode[0] = 5;
    pat[0] = 16'($urandom) | 16'h0001;
    glitch[0] = 0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (cyc < 500 && abcd[0] != 4'd7) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_abcd7", abcd[0], 7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_abcd", abcd[0], 0);
    check("arst_busy", busy[0], 0);
    check("arst_done", done[0], 0);
    check("arst_table", tbl[0], 0);
    check("arst_ones", ones[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev[0] = 16'h0;
    prev[1] = 16'h0;
    @(negedge clk);
    scan(0, 5, 16'($urandom), 0, 0);
    scan(1, 5, 16'($urandom), 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Drives every 4-bit input vector A,B,C,D onto an external combinational gate-level circuit in ascending order.
- Waits a programmable settle time after each vector, then samples the circuit's single output F.
- Assembles the complete truth table and a count of its true minterms.
- Sits at the driving/reading end of the gate-level function interface and serves as the lab's hardware checker for Mano-style schematics.

Parameters:
N_IN, 4, number of circuit inputs; vectors range 0 .. 2**N_IN-1
SETTLE, 2, idle cycles after driving a vector before F is sampled (0 allowed, max 15)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a full scan; accepted only in IDLE
abcd  output  N_IN  vector driven to the circuit; MSB = A, LSB = D
f  input  1  circuit output for the vector currently driven
busy  output  1  high from the cycle after start is accepted until the last sample
done  output  1  one-cycle pulse; table and ones are valid from this cycle
table  output  2**N_IN  bit i = F for vector i
ones  output  N_IN+1  number of set bits in table

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, abcd=0, busy=0, done=0, table=0, ones=0, settle count=0. Reset mid-scan aborts immediately; no partial result survives.
- States: IDLE, WAIT, DONE.
- IDLE: abcd=0, busy=0.
  - start=1 at an edge -> WAIT next cycle with abcd=0, cnt=SETTLE, table=0, ones=0, busy=1.
  - table and ones keep the previous scan's result until that accepting edge.
- WAIT, cnt>0: decrement cnt; abcd held.
- WAIT, cnt==0: at the edge, table[abcd] <= f and ones <= ones + f.
  - If abcd == 2**N_IN-1 -> DONE, busy <= 0.
  - Else abcd <= abcd+1 and cnt <= SETTLE.
- DONE: done=1 for exactly one cycle, then IDLE. abcd returns to 0 in IDLE.
- Timing:
  - Each vector is driven for SETTLE+1 cycles.
  - busy is high for exactly 2**N_IN*(SETTLE+1) cycles.
  - done asserts on the cycle after busy falls.
  - start sampled high at edge k -> done high during cycle k+1+2**N_IN*(SETTLE+1).
- f is sampled only at the cnt==0 edge; glitches during settle cycles are ignored by construction.
- start while busy or during DONE is ignored (no queueing, no restart).
- Width rules:
  - ones is N_IN+1 bits and never wraps (max 2**N_IN).
  - abcd increments without wrap; the terminal vector exits to DONE.
  - cnt is 4 bits.
- All outputs are registered; no combinational path from f or start to any output.

Decomposition:
- Shared include/package: state encodings IDLE=2'b00, WAIT=2'b01, DONE=2'b10 as localparams; default N_IN and SETTLE constants.
- One sub-module: settle_timer.
  - Loadable 4-bit down-counter with load, load_value and zero flag.
  - Async active-low reset on rst_n.
- Vector counter and table/ones accumulation stay in the top FSM.

Test Plan:
- f driven by model F=(A xor B)&(C | ~D), SETTLE=2, pulse start -> done after 48 busy cycles, table=16'h0DD0, ones=6.
- f tied to 1 -> table=16'hFFFF, ones=16 (no wrap of ones); f tied to 0 -> table=16'h0000, ones=0.
- SETTLE=0, f=abcd[0] -> busy high exactly 16 cycles, abcd steps every cycle, table=16'hAAAA, ones=8.
- f toggles during the settle cycles but is stable at the cnt==0 edge with F=parity(abcd) -> table=16'h6996; settle-cycle values never appear in table.
- start pulsed again while busy and during the done cycle -> no restart, single done pulse, result unchanged; next start from IDLE clears table at acceptance.
- rst_n asserted low asynchronously mid-scan (abcd=7) -> abcd, busy, done, table, ones all 0 immediately; fresh start afterwards produces a correct full table.
